alarm_clock_multi: RTL and testbench

Parametrised 24-hour BCD real-time clock with NUM_ALARMS independently loadable, individually enabled alarms, auto-timeout ringing and optional snooze. Sits between the board oscillator (clk pin) and the seven-segment display decoders and alarm buzzer driver. It generalises the single-alarm clock in three ways: configurable input frequency, a multi-channel alarm bank, and a ringing state machine.

---
 rtl/alarm_clock_multi_pkg.sv | 49 ++++
 rtl/alarm_clock_multi_tick_gen.sv | 29 ++
 rtl/alarm_clock_multi.sv | 233 +++++++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_multi_pkg.sv
// Shared types, BCD wrap limits and the hh:mm load-validity check for the
// multi-alarm real-time clock.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } ring_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic [2:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
    } bcd_hhmm_t;

    localparam int BCD_UNITS_MAX = 9;
    localparam int BCD_TENS_MAX  = 5;
    localparam int HOUR_MAX      = 23;

    // Hour tens/units limits are derived from HOUR_MAX so 2x hours stop at 23.
    function automatic logic bcd_hhmm_valid(
        input logic [1:0] h1,
        input logic [3:0] h0,
        input logic [2:0] m1,
        input logic [3:0] m0
    );
        logic ok;
        ok = (32'(h1) <= HOUR_MAX / 10) &&
             (32'(h0) <= BCD_UNITS_MAX) &&
             (32'(m1) <= BCD_TENS_MAX) &&
             (32'(m0) <= BCD_UNITS_MAX);
        if ((32'(h1) == HOUR_MAX / 10) && (32'(h0) > HOUR_MAX % 10)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/alarm_clock_multi_tick_gen.sv
// CLK_HZ prescaler: emits a one-cycle tick_1s every CLK_HZ clocks; the
// synchronous clear restarts the second so a time load begins a full second.
module rtc_tick_gen #(
    parameter int CLK_HZ = 125000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_1s
);

    localparam int              CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0]   LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_1s = (count == LAST);

endmodule

// File: rtl/alarm_clock_multi.sv
// 24-hour BCD clock with a bank of NUM_ALARMS alarms and a ring/snooze FSM.
// Optional feature macro: ALARM_SNOOZE_EN builds the SNOOZE state and countdown.
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ     = 125000000,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_time,
    input  logic                  load_alarm,
    input  logic [AW-1:0]         alarm_sel,
    input  logic                  alarm_en_in,
    input  logic [1:0]            set_h1,
    input  logic [3:0]            set_h0,
    input  logic [2:0]            set_m1,
    input  logic [3:0]            set_m0,
    input  logic                  off_alarm,
    input  logic                  snooze,
    output logic                  tick_1s,
    output logic [1:0]            h1out,
    output logic [3:0]            h0out,
    output logic [2:0]            m1out,
    output logic [3:0]            m0out,
    output logic [2:0]            s1out,
    output logic [3:0]            s0out,
    output logic                  alarm,
    output logic [NUM_ALARMS-1:0] alarm_hit,
    output logic                  load_err
);

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    bcd_time_t             now;
    bcd_hhmm_t             al_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] al_en;
    logic [NUM_ALARMS-1:0] match_vec;
    logic                  tick_d;
    logic                  set_ok;
    logic                  sel_ok;
    logic                  time_ok;
    logic                  alarm_ok;
    ring_state_t           state;
    logic [7:0]            ring_cnt;

`ifdef ALARM_SNOOZE_EN
    localparam logic [11:0] SNOOZE_LAST = 12'(SNOOZE_MIN * 60 - 1);
    logic [11:0] snooze_cnt;
`else
    logic unused_snooze;
    assign unused_snooze = snooze;
`endif

    assign set_ok   = bcd_hhmm_valid(set_h1, set_h0, set_m1, set_m0);
    assign sel_ok   = (32'(alarm_sel) < NUM_ALARMS);
    assign time_ok  = load_time && set_ok;
    assign alarm_ok = load_alarm && set_ok && sel_ok;

    rtc_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (time_ok),
        .tick_1s (tick_1s)
    );

    // Straight BCD ripple: each digit only advances when all lower digits wrap.
    function automatic bcd_time_t next_second(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (32'(t.s0) != BCD_UNITS_MAX) begin
            n.s0 = t.s0 + 4'd1;
        end else begin
            n.s0 = '0;
            if (32'(t.s1) != BCD_TENS_MAX) begin
                n.s1 = t.s1 + 3'd1;
            end else begin
                n.s1 = '0;
                if (32'(t.m0) != BCD_UNITS_MAX) begin
                    n.m0 = t.m0 + 4'd1;
                end else begin
                    n.m0 = '0;
                    if (32'(t.m1) != BCD_TENS_MAX) begin
                        n.m1 = t.m1 + 3'd1;
                    end else begin
                        n.m1 = '0;
                        if ((32'(t.h1) == HOUR_MAX / 10) && (32'(t.h0) == HOUR_MAX % 10)) begin
                            n.h1 = '0;
                            n.h0 = '0;
                        end else if (32'(t.h0) == BCD_UNITS_MAX) begin
                            n.h0 = '0;
                            n.h1 = t.h1 + 2'd1;
                        end else begin
                            n.h0 = t.h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return n;
    endfunction

    // tick_d is withheld on a time load so a loaded hh:mm:00 never matches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            now      <= '0;
            tick_d   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (time_ok) begin
                now <= {set_h1, set_h0, set_m1, set_m0, 3'd0, 4'd0};
            end else if (tick_1s) begin
                now <= next_second(now);
            end
            tick_d   <= tick_1s && !time_ok;
            load_err <= (load_time && !set_ok) || (load_alarm && !(set_ok && sel_ok));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_time[i] <= '0;
            end
            al_en <= '0;
        end else if (alarm_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (32'(alarm_sel) == i) begin
                    al_time[i] <= {set_h1, set_h0, set_m1, set_m0};
                    al_en[i]   <= alarm_en_in;
                end
            end
        end
    end

    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match_vec[i] = tick_d && al_en[i] &&
                           (al_time[i] == {now.h1, now.h0, now.m1, now.m0}) &&
                           (now.s1 == 3'd0) && (now.s0 == 4'd0);
        end
    end

    // Priority in RING: off_alarm, then snooze, then a fresh match, then timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            alarm     <= 1'b0;
            alarm_hit <= '0;
            ring_cnt  <= '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (!off_alarm && (|match_vec)) begin
                        state     <= RING;
                        alarm     <= 1'b1;
                        alarm_hit <= match_vec;
                        ring_cnt  <= RING_LAST;
                    end
                end
                RING: begin
                    if (off_alarm) begin
                        state     <= IDLE;
                        alarm     <= 1'b0;
                        alarm_hit <= '0;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state      <= SNOOZE;
                        alarm      <= 1'b0;
                        alarm_hit  <= alarm_hit | match_vec;
                        snooze_cnt <= SNOOZE_LAST;
`endif
                    end else if (|match_vec) begin
                        alarm_hit <= alarm_hit | match_vec;
                        ring_cnt  <= RING_LAST;
                    end else if (tick_1s) begin
                        if (ring_cnt == 8'd0) begin
                            state     <= IDLE;
                            alarm     <= 1'b0;
                            alarm_hit <= '0;
                        end else begin
                            ring_cnt <= ring_cnt - 8'd1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (off_alarm) begin
                        state     <= IDLE;
                        alarm     <= 1'b0;
                        alarm_hit <= '0;
                    end else if (|match_vec) begin
                        state     <= RING;
                        alarm     <= 1'b1;
                        alarm_hit <= alarm_hit | match_vec;
                        ring_cnt  <= RING_LAST;
                    end else if (tick_1s) begin
                        if (snooze_cnt == 12'd0) begin
                            state    <= RING;
                            alarm    <= 1'b1;
                            ring_cnt <= RING_LAST;
                        end else begin
                            snooze_cnt <= snooze_cnt - 12'd1;
                        end
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    alarm     <= 1'b0;
                    alarm_hit <= '0;
                end
            endcase
        end
    end

    assign h1out = now.h1;
    assign h0out = now.h0;
    assign m1out = now.m1;
    assign m0out = now.m0;
    assign s1out = now.s1;
    assign s0out = now.s0;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi at CLK_HZ=4, NUM_ALARMS=4: a load
// vector table followed by hand-timed ring, snooze, wrap and reset sequences.
module tb_alarm_clock_multi;

    localparam int CLK_HZ     = 4;
    localparam int NUM_ALARMS = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  load_time = 1'b0;
    logic                  load_alarm = 1'b0;
    logic [1:0]            alarm_sel = '0;
    logic                  alarm_en_in = 1'b0;
    logic [1:0]            set_h1 = '0;
    logic [3:0]            set_h0 = '0;
    logic [2:0]            set_m1 = '0;
    logic [3:0]            set_m0 = '0;
    logic                  off_alarm = 1'b0;
    logic                  snooze = 1'b0;
    logic                  tick_1s;
    logic [1:0]            h1out;
    logic [3:0]            h0out;
    logic [2:0]            m1out;
    logic [3:0]            m0out;
    logic [2:0]            s1out;
    logic [3:0]            s0out;
    logic                  alarm;
    logic [NUM_ALARMS-1:0] alarm_hit;
    logic                  load_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       lt;
        logic       la;
        logic [1:0] sel;
        logic       en;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [2:0] m1;
        logic [3:0] m0;
        logic       exp_err;
        logic [15:0] exp_hhmm;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    alarm_clock_multi #(
        .CLK_HZ     (CLK_HZ),
        .NUM_ALARMS (NUM_ALARMS),
        .RING_SEC   (60),
        .SNOOZE_MIN (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_time   (load_time),
        .load_alarm  (load_alarm),
        .alarm_sel   (alarm_sel),
        .alarm_en_in (alarm_en_in),
        .set_h1      (set_h1),
        .set_h0      (set_h0),
        .set_m1      (set_m1),
        .set_m0      (set_m0),
        .off_alarm   (off_alarm),
        .snooze      (snooze),
        .tick_1s     (tick_1s),
        .h1out       (h1out),
        .h0out       (h0out),
        .m1out       (m1out),
        .m0out       (m0out),
        .s1out       (s1out),
        .s0out       (s0out),
        .alarm       (alarm),
        .alarm_hit   (alarm_hit),
        .load_err    (load_err)
    );

    function automatic logic [15:0] hhmm();
        return {2'b00, h1out, h0out, 1'b0, m1out, m0out};
    endfunction

    function automatic logic [7:0] ss();
        return {1'b0, s1out, s0out};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        set_h1      = v.h1;
        set_h0      = v.h0;
        set_m1      = v.m1;
        set_m0      = v.m0;
        alarm_sel   = v.sel;
        alarm_en_in = v.en;
        load_time   = v.lt;
        load_alarm  = v.la;
        step(1);
        load_time  = 1'b0;
        load_alarm = 1'b0;
    endtask

    task automatic do_load_time(input logic [1:0] h1, input logic [3:0] h0,
                                input logic [2:0] m1, input logic [3:0] m0);
        set_h1 = h1; set_h0 = h0; set_m1 = m1; set_m0 = m0;
        load_time = 1'b1;
        step(1);
        load_time = 1'b0;
    endtask

    task automatic do_load_alarm(input logic [1:0] sel, input logic en,
                                 input logic [1:0] h1, input logic [3:0] h0,
                                 input logic [2:0] m1, input logic [3:0] m0);
        set_h1 = h1; set_h0 = h0; set_m1 = m1; set_m0 = m0;
        alarm_sel = sel; alarm_en_in = en;
        load_alarm = 1'b1;
        step(1);
        load_alarm = 1'b0;
    endtask

    task automatic pulse_off();
        off_alarm = 1'b1;
        step(1);
        off_alarm = 1'b0;
    endtask

    initial begin
        //                lt    la    sel   en    h1    h0     m1    m0     err   hhmm
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'd2,  3'd3, 4'd4,  1'b0, 16'h1234};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'd4,  3'd0, 4'd0,  1'b1, 16'h1234};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h1234};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'd2,  3'd6, 4'd0,  1'b1, 16'h1234};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd10, 3'd0, 4'd0,  1'b1, 16'h1234};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 4'd0,  3'd0, 4'd0,  1'b1, 16'h1234};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'd2,  3'd3, 4'd10, 1'b1, 16'h1234};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'd9,  3'd5, 4'd9,  1'b0, 16'h1959};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'd3,  3'd5, 4'd9,  1'b0, 16'h2359};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 4'd2,  3'd6, 4'd0,  1'b1, 16'h2359};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 4'd0,  3'd0, 4'd0,  1'b0, 16'h2359};
        vecs[11] = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 1'b1, 2'd2, 4'd4,  3'd0, 4'd0,  1'b1, 16'h0000};
        vecs[13] = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h0000};
        vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h0000};
        vecs[15] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h0000};
        vecs[16] = '{1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 4'd0,  3'd0, 4'd0,  1'b0, 16'h0000};

        $display("[TB] reset state");
        step(2);
        check_output("reset hhmm", 32'(hhmm()), 32'h0000);
        check_output("reset ss", 32'(ss()), 32'h00);
        check_output("reset alarm", 32'(alarm), 32'h0);
        check_output("reset alarm_hit", 32'(alarm_hit), 32'h0);
        check_output("reset load_err", 32'(load_err), 32'h0);
        check_output("reset tick_1s", 32'(tick_1s), 32'h0);

        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check_output($sformatf("tick k=%0d", k), 32'(tick_1s), ((k % 4) == 3) ? 32'h1 : 32'h0);
        end
        check_output("seconds after 2 ticks", 32'(ss()), 32'h02);

        $display("[TB] load vector table");
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d load_err", i), 32'(load_err), 32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d hhmm", i), 32'(hhmm()), 32'(vecs[i].exp_hhmm));
        end

        $display("[TB] midnight wrap");
        do_load_time(2'd2, 4'd3, 3'd5, 4'd9);
        step(236);
        check_output("wrap pre hhmm", 32'(hhmm()), 32'h2359);
        check_output("wrap pre ss", 32'(ss()), 32'h59);
        check_output("wrap tick low", 32'(tick_1s), 32'h0);
        step(3);
        check_output("wrap tick high", 32'(tick_1s), 32'h1);
        step(1);
        check_output("wrap hhmm", 32'(hhmm()), 32'h0000);
        check_output("wrap ss", 32'(ss()), 32'h00);

        $display("[TB] single alarm ring and timeout");
        do_load_time(2'd0, 4'd7, 3'd2, 4'd9);
        do_load_alarm(2'd2, 1'b1, 2'd0, 4'd7, 3'd3, 4'd0);
        step(239);
        check_output("ring2 time", 32'(hhmm()), 32'h0730);
        check_output("ring2 not yet", 32'(alarm), 32'h0);
        step(1);
        check_output("ring2 alarm", 32'(alarm), 32'h1);
        check_output("ring2 hit", 32'(alarm_hit), 32'h4);
        step(238);
        check_output("ring2 still ringing", 32'(alarm), 32'h1);
        step(1);
        check_output("ring2 timeout alarm", 32'(alarm), 32'h0);
        check_output("ring2 timeout hit", 32'(alarm_hit), 32'h0);

        $display("[TB] snooze");
        do_load_time(2'd0, 4'd7, 3'd5, 4'd9);
        do_load_alarm(2'd0, 1'b1, 2'd0, 4'd8, 3'd0, 4'd0);
        step(240);
        check_output("ring0 alarm", 32'(alarm), 32'h1);
        check_output("ring0 hit", 32'(alarm_hit), 32'h1);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check_output("snooze alarm low", 32'(alarm), 32'h0);
        check_output("snooze hit held", 32'(alarm_hit), 32'h1);
        step(1197);
        check_output("snooze end-1 alarm", 32'(alarm), 32'h0);
        step(1);
        check_output("resnooze alarm", 32'(alarm), 32'h1);
        check_output("resnooze hit", 32'(alarm_hit), 32'h1);
        check_output("resnooze time", 32'(hhmm()), 32'h0805);
`else
        check_output("snooze ignored", 32'(alarm), 32'h1);
        check_output("snooze ignored hit", 32'(alarm_hit), 32'h1);
`endif
        pulse_off();
        check_output("off alarm", 32'(alarm), 32'h0);
        check_output("off hit", 32'(alarm_hit), 32'h0);

        $display("[TB] two channels and off vs match");
        do_load_time(2'd1, 4'd1, 3'd5, 4'd9);
        do_load_alarm(2'd1, 1'b1, 2'd1, 4'd2, 3'd0, 4'd0);
        do_load_alarm(2'd3, 1'b1, 2'd1, 4'd2, 3'd0, 4'd0);
        do_load_alarm(2'd0, 1'b1, 2'd1, 4'd2, 3'd0, 4'd1);
        step(238);
        check_output("dual alarm", 32'(alarm), 32'h1);
        check_output("dual hit", 32'(alarm_hit), 32'ha);
        pulse_off();
        check_output("dual off alarm", 32'(alarm), 32'h0);
        check_output("dual off hit", 32'(alarm_hit), 32'h0);
        step(238);
        check_output("1201 time", 32'(hhmm()), 32'h1201);
        check_output("1201 ss", 32'(ss()), 32'h00);
        pulse_off();
        check_output("off beats match", 32'(alarm), 32'h0);
        step(1);
        check_output("off beats match later", 32'(alarm), 32'h0);
        check_output("off beats match hit", 32'(alarm_hit), 32'h0);

        $display("[TB] async reset while ringing");
        do_load_time(2'd1, 4'd1, 3'd5, 4'd9);
        step(241);
        check_output("pre-reset alarm", 32'(alarm), 32'h1);
        check_output("pre-reset hit", 32'(alarm_hit), 32'ha);
        #2;
        reset = 1'b0;
        #1;
        check_output("async reset alarm", 32'(alarm), 32'h0);
        check_output("async reset hit", 32'(alarm_hit), 32'h0);
        step(2);
        reset = 1'b1;
        check_output("post-reset hhmm", 32'(hhmm()), 32'h0000);
        check_output("post-reset ss", 32'(ss()), 32'h00);
        do_load_time(2'd1, 4'd1, 3'd5, 4'd9);
        step(241);
        check_output("alarms disabled after reset", 32'(alarm), 32'h0);
        check_output("time after reset run", 32'(hhmm()), 32'h1200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
